// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants for the MIPS fetch stage
package mips_pkg;

  localparam int          NB_WIDTH_DEF   = 32;
  localparam logic [31:0] RESET_ADDR_DEF = 32'h0000_0000;
  localparam int          PC_INCR        = 4;

endpackage

// File: rtl/program_counter.sv
// rtl/program_counter.sv - IF-stage PC register with jump load, stall/halt hold and +4 link output
module program_counter
  import mips_pkg::*;
#(
  parameter int                 NB_WIDTH   = NB_WIDTH_DEF,
  parameter logic [NB_WIDTH-1:0] RESET_ADDR = NB_WIDTH'(RESET_ADDR_DEF)
) (
  input  logic                clk,
  input  logic                i_rst_n,
  input  logic [NB_WIDTH-1:0] i_addr2jump,
  input  logic                i_valid,
  input  logic                i_halt,
  input  logic                i_stall,
  output logic [NB_WIDTH-1:0] o_pcounter,
  output logic [NB_WIDTH-1:0] o_pcounter4
);

  localparam logic [NB_WIDTH-1:0] INCR = NB_WIDTH'(PC_INCR);

  logic [NB_WIDTH-1:0] pc_q;
  logic [NB_WIDTH-1:0] pc_d;
  logic [NB_WIDTH-1:0] pc_plus4;

  // Modulo-2^NB_WIDTH add; the same sum feeds both the link output and the sequential next PC.
  assign pc_plus4 = pc_q + INCR;

  // Freeze wins over a jump so a dropped jump must be re-presented by the producer.
  always_comb begin
    pc_d = pc_q;
    if (i_halt || i_stall) begin
      pc_d = pc_q;
    end else if (i_valid) begin
      pc_d = i_addr2jump;
    end else begin
      pc_d = pc_plus4;
    end
  end

  // Despite its name, i_rst_n is active-high.
  always_ff @(posedge clk) begin
    if (i_rst_n) begin
      pc_q <= RESET_ADDR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign o_pcounter  = pc_q;
  assign o_pcounter4 = pc_plus4;

endmodule

// File: tb/tb_program_counter.sv
// tb/tb_program_counter.sv - scoreboard bench for program_counter with directed vectors
module tb_program_counter;

  logic        clk;
  logic        i_rst_n;
  logic [31:0] i_addr2jump;
  logic        i_valid;
  logic        i_halt;
  logic        i_stall;
  logic [31:0] o_pcounter;
  logic [31:0] o_pcounter4;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] pc4;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  bit   stim_done   = 0;

  program_counter dut (
    .clk         (clk),
    .i_rst_n     (i_rst_n),
    .i_addr2jump (i_addr2jump),
    .i_valid     (i_valid),
    .i_halt      (i_halt),
    .i_stall     (i_stall),
    .o_pcounter  (o_pcounter),
    .o_pcounter4 (o_pcounter4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one edge's worth of inputs on the falling edge and queue what the next rising edge must produce.
  task automatic apply(input string name, input logic rst, input logic halt, input logic stall,
                       input logic valid, input logic [31:0] addr,
                       input logic [31:0] exp_pc, input logic [31:0] exp_pc4);
    exp_t e;
    @(negedge clk);
    i_rst_n     = rst;
    i_halt      = halt;
    i_stall     = stall;
    i_valid     = valid;
    i_addr2jump = addr;
    e.name = name;
    e.pc   = exp_pc;
    e.pc4  = exp_pc4;
    exp_q.push_back(e);
  endtask

  // Monitor: the PC output is presented once per rising edge; compare 1 time unit after it.
  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors++;
      if (o_pcounter !== e.pc || o_pcounter4 !== e.pc4) begin
        miscompares++;
        $display("FAIL %s: pc=%h pc4=%h, expected pc=%h pc4=%h",
                 e.name, o_pcounter, o_pcounter4, e.pc, e.pc4);
      end
    end
  end

  initial begin
    int budget;
    i_rst_n = 1'b0; i_halt = 1'b0; i_stall = 1'b0; i_valid = 1'b0; i_addr2jump = 32'h0;

    //     name               rst halt stall valid addr           pc             pc4
    apply("reset",            1, 0, 0, 0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0004);
    apply("idle1",            0, 0, 0, 0, 32'h0000_0000, 32'h0000_0004, 32'h0000_0008);
    apply("idle2",            0, 0, 0, 0, 32'h0000_0000, 32'h0000_0008, 32'h0000_000C);
    apply("jump_20",          0, 0, 0, 1, 32'h0000_0020, 32'h0000_0020, 32'h0000_0024);
    apply("after_jump",       0, 0, 0, 0, 32'h0000_0000, 32'h0000_0024, 32'h0000_0028);
    apply("halt_hold",        0, 1, 0, 0, 32'h0000_0000, 32'h0000_0024, 32'h0000_0028);
    apply("halt_release",     0, 0, 0, 0, 32'h0000_0000, 32'h0000_0028, 32'h0000_002C);
    apply("stall_hold",       0, 0, 1, 0, 32'h0000_0000, 32'h0000_0028, 32'h0000_002C);
    apply("stall_release",    0, 0, 0, 0, 32'h0000_0000, 32'h0000_002C, 32'h0000_0030);
    apply("stall_drop_jump",  0, 0, 1, 1, 32'h0000_0100, 32'h0000_002C, 32'h0000_0030);
    apply("halt_drop_jump",   0, 1, 0, 1, 32'h0000_0100, 32'h0000_002C, 32'h0000_0030);
    apply("both_drop_jump",   0, 1, 1, 1, 32'h0000_0100, 32'h0000_002C, 32'h0000_0030);
    apply("held_jump_lands",  0, 0, 0, 1, 32'h0000_0100, 32'h0000_0100, 32'h0000_0104);
    apply("jump_top",         0, 0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000);
    apply("wrap",             0, 0, 0, 0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0004);
    apply("idle_after_wrap",  0, 0, 0, 0, 32'h0000_0000, 32'h0000_0004, 32'h0000_0008);
    apply("jump_misaligned",  0, 0, 0, 1, 32'h0000_0013, 32'h0000_0013, 32'h0000_0017);
    apply("misaligned_inc",   0, 0, 0, 0, 32'h0000_0000, 32'h0000_0017, 32'h0000_001B);
    apply("rst_over_jump",    1, 0, 0, 1, 32'h0000_0200, 32'h0000_0000, 32'h0000_0004);
    apply("post_rst_idle",    0, 0, 0, 0, 32'h0000_0000, 32'h0000_0004, 32'h0000_0008);
    apply("rst_over_stall",   1, 0, 1, 1, 32'h0000_0300, 32'h0000_0000, 32'h0000_0004);
    apply("rst_over_halt",    1, 1, 0, 0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0004);
    apply("post_rst_jump",    0, 0, 0, 1, 32'h0000_0040, 32'h0000_0040, 32'h0000_0044);
    apply("final_idle",       0, 0, 0, 0, 32'h0000_0000, 32'h0000_0044, 32'h0000_0048);

    @(negedge clk);
    i_valid = 1'b0;
    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
